// File: rtl/race_ctrl.sv
// ============================================================================
// race_ctrl : drag-race phase sequencer (countdown lights, race timer, winner,
//             mux select). Optional false-start detection: FALSE_START_EN.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module race_ctrl #(
    parameter int STEP_CYCLES = 50_000_000,
    parameter int MS_CYCLES   = 100_000,
    parameter int TIME_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              p1_thr,
    input  logic              p2_thr,
    input  logic              p1_fin,
    input  logic              p2_fin,
    output logic              sel,
    output logic [2:0]        lights,
    output logic              go,
    output logic              race_active,
    output logic [TIME_W-1:0] race_time,
    output logic [1:0]        winner,
    output logic [1:0]        fault
);

    localparam int c_STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int c_MS_W   = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_CYCLES - 1);
    localparam logic [c_MS_W-1:0]   c_MS_LAST   = c_MS_W'(MS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_RACE   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t              state_q;
    logic [c_STEP_W-1:0] step_q;
    logic [c_MS_W-1:0]   ms_q;
    logic                sel_q;
    logic [2:0]          lights_q;
    logic                go_q;
    logic                race_active_q;
    logic [TIME_W-1:0]   race_time_q;
    logic [1:0]          winner_q;
    logic [TIME_W-1:0]   w_time_inc;

`ifdef FALSE_START_EN
    logic [1:0]          fault_q;
    assign fault = fault_q;
`else
    logic                w_unused_thr;
    assign w_unused_thr = p1_thr ^ p2_thr;
    assign fault        = 2'b00;
`endif

    assign w_time_inc = race_time_q + TIME_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            step_q        <= '0;
            ms_q          <= '0;
            sel_q         <= 1'b0;
            lights_q      <= 3'b000;
            go_q          <= 1'b0;
            race_active_q <= 1'b0;
            race_time_q   <= '0;
            winner_q      <= 2'b00;
`ifdef FALSE_START_EN
            fault_q       <= 2'b00;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_FINISH: begin
                    if (start) begin
                        state_q       <= S_COUNT;
                        step_q        <= '0;
                        sel_q         <= 1'b0;
                        lights_q      <= 3'b001;
                        go_q          <= 1'b0;
                        race_active_q <= 1'b0;
                        race_time_q   <= '0;
                        winner_q      <= 2'b00;
`ifdef FALSE_START_EN
                        fault_q       <= 2'b00;
`endif
                    end
                end

                S_COUNT: begin
`ifdef FALSE_START_EN
                    // Jumping the lights hands the race to the other player.
                    if (p1_thr || p2_thr) begin
                        state_q  <= S_FINISH;
                        lights_q <= 3'b000;
                        fault_q  <= {p2_thr, p1_thr};
                        winner_q <= {p1_thr & ~p2_thr, p2_thr & ~p1_thr};
                    end else
`endif
                    if (step_q == c_STEP_LAST) begin
                        step_q <= '0;
                        if (lights_q == 3'b111) begin
                            state_q       <= S_RACE;
                            ms_q          <= '0;
                            lights_q      <= 3'b000;
                            go_q          <= 1'b1;
                            sel_q         <= 1'b1;
                            race_active_q <= 1'b1;
                        end else begin
                            lights_q <= {lights_q[1:0], 1'b1};
                        end
                    end else begin
                        step_q <= step_q + c_STEP_W'(1);
                    end
                end

                S_RACE: begin
                    if (p1_fin || p2_fin) begin
                        state_q       <= S_FINISH;
                        winner_q      <= {p2_fin, p1_fin};
                        sel_q         <= 1'b0;
                        go_q          <= 1'b0;
                        race_active_q <= 1'b0;
                    end else if (ms_q == c_MS_LAST) begin
                        ms_q        <= '0;
                        race_time_q <= w_time_inc;
                        // Timer reaching all-ones ends the race with no winner.
                        if (&w_time_inc) begin
                            state_q       <= S_FINISH;
                            winner_q      <= 2'b00;
                            sel_q         <= 1'b0;
                            go_q          <= 1'b0;
                            race_active_q <= 1'b0;
                        end
                    end else begin
                        ms_q <= ms_q + c_MS_W'(1);
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sel         = sel_q;
    assign lights      = lights_q;
    assign go          = go_q;
    assign race_active = race_active_q;
    assign race_time   = race_time_q;
    assign winner      = winner_q;

endmodule

`default_nettype wire
